hs_burst_master: RTL and testbench

Parametrised successor to the fixed 4-byte burst master. Sends a runtime-programmable burst of DATA_W-bit words over the 4-phase req/ack link. Words are pulled one at a time from an upstream valid/ready source instead of a hard-coded table. Adds ack timeout/abort with error reporting, and a status word count. Sits between a local producer (e.g. a FIFO) and the existing slave-side link FSM.

---
 rtl/hs_link_pkg.sv | 29 ++
 rtl/hs_timeout_ctr.sv | 50 +++++
 rtl/hs_burst_master.sv | 161 ++++++++++++++++
 tb/tb_hs_burst_master.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_link_pkg.sv
// hs_link_pkg
// Shared definitions for the 4-phase req/ack link: burst master state
// encoding, default link constants and a width helper used by both the
// master-side timeout counter and the slave-side link block.
package hs_link_pkg;

  localparam int LINK_DATA_W      = 8;
  localparam int LINK_MAX_BURST   = 16;
  localparam int LINK_TIMEOUT_CYC = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_REQ   = 3'd2,
    ST_REL   = 3'd3,
    ST_DONE  = 3'd4
  } hs_state_e;

  // Ceiling log2 with a floor of 1 bit, so a counter that only ever needs
  // to hold 0 still gets a legal vector width.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/hs_timeout_ctr.sv
// hs_timeout_ctr
// Counts consecutive cycles in which the awaited ack level is missing and
// flags the cycle in which that count would reach TIMEOUT_CYC.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   clear     - return the count to zero (waiting condition satisfied or
//               not in a waiting state)
//   enable    - awaited ack level absent this cycle; count advances
//   expired   - this is the TIMEOUT_CYC-th consecutive absent cycle
// TIMEOUT_CYC = 0 removes the counter and holds expired low.
module hs_timeout_ctr
  import hs_link_pkg::*;
#(
  parameter int TIMEOUT_CYC = LINK_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = clog2_min1(TIMEOUT_CYC + 1);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst, clear, enable};
      assign expired = 1'b0;
    end else begin : g_on
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (enable) begin
          cnt <= cnt + 1'b1;
        end
      end

      // Fires one cycle early relative to the registered count so the
      // abort lands exactly TIMEOUT_CYC absent cycles after entry.
      assign expired = enable && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/hs_burst_master.sv
// hs_burst_master
// Sends a runtime-programmable burst of DATA_W-bit words over a 4-phase
// req/ack link, pulling each word from an upstream valid/ready source.
// Aborts with a sticky error if ack does not rise/fall within TIMEOUT_CYC.
// Ports:
//   clk, rst         - system clock, synchronous active-high reset
//   start, burst_len - burst request and length (sampled in IDLE only)
//   src_valid/src_data/src_ready - upstream word source handshake
//   req, data, ack   - 4-phase link to the slave
//   busy, done, err  - in-progress flag, end-of-burst pulse, sticky timeout
//   count            - words fully handshaken in the current/last burst
//
// state | meaning
// IDLE  | waiting for start
// FETCH | requesting next word from the source
// REQ   | req high, data valid, waiting for ack to rise
// REL   | req low, waiting for ack to fall to close the handshake
// DONE  | one-cycle end-of-burst pulse (success or abort)
module hs_burst_master
  import hs_link_pkg::*;
#(
  parameter  int DATA_W      = LINK_DATA_W,
  parameter  int MAX_BURST   = LINK_MAX_BURST,
  parameter  int TIMEOUT_CYC = LINK_TIMEOUT_CYC,
  localparam int LEN_W       = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              req,
  output logic [DATA_W-1:0] data,
  input  logic              ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  count
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

  hs_state_e        state, state_nxt;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W-1:0] count_inc;
  logic             take_start;
  logic             accept;
  logic             word_done;
  logic             abort;
  logic             wait_absent;
  logic             expired;

  assign len_clamped = (burst_len > MAX_LEN) ? MAX_LEN : burst_len;
  assign count_inc   = count + 1'b1;

  // Counter runs only while the awaited ack level is missing; any other
  // cycle (including the one that leaves REQ/REL) zeroes it, so each
  // entry into REQ or REL starts from 0.
  assign wait_absent = ((state == ST_REQ) && !ack) ||
                       ((state == ST_REL) &&  ack);

  hs_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!wait_absent),
    .enable  (wait_absent),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    take_start = 1'b0;
    accept     = 1'b0;
    word_done  = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          take_start = 1'b1;
          state_nxt  = (burst_len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        // A lingering ack must drop before a new word is taken, otherwise
        // the slave could see a handshake that never happened.
        if (src_valid && !ack) begin
          accept    = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack) begin
          state_nxt = ST_REL;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_REL: begin
        if (!ack) begin
          word_done = 1'b1;
          state_nxt = (count_inc == len) ? ST_DONE : ST_FETCH;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len   <= '0;
      count <= '0;
      data  <= '0;
      err   <= 1'b0;
    end else begin
      if (take_start) begin
        len   <= len_clamped;
        count <= '0;
        err   <= 1'b0;
      end
      if (accept) begin
        data <= src_data;
      end
      if (word_done) begin
        count <= count_inc;
      end
      if (abort) begin
        err <= 1'b1;
      end
    end
  end

  // src_ready mirrors the FETCH accept condition so the source never sees
  // a transfer the master did not actually take.
  assign src_ready = (state == ST_FETCH) && !ack;
  assign req       = (state == ST_REQ);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_hs_burst_master.sv
// tb_hs_burst_master
// Randomised bench for hs_burst_master: a queue-based word source, a
// behavioural ack slave with random response delay (or a stuck word), and
// a transaction-level reference that tracks which words were handed over,
// which words the link carried, and what each burst should end with.
module tb_hs_burst_master;

  localparam int DW  = 8;
  localparam int MB  = 16;
  localparam int TMO = 8;
  localparam int LW  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_ready;
  logic          req;
  logic [DW-1:0] data;
  logic          ack = 1'b0;
  logic          busy;
  logic          done;
  logic          err;
  logic [LW-1:0] count;

  always #5 clk = ~clk;

  hs_burst_master #(
    .DATA_W      (DW),
    .MAX_BURST   (MB),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .burst_len (burst_len),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Source, slave and reference-model state
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] acc_q[$];
  int            src_mode   = 0;
  int            src_phase  = 0;
  int            max_dly    = 0;
  int            dly_cnt    = 0;
  int            stuck_word = 0;
  int            rises      = 0;
  int            req_hi     = 0;
  int            done_cnt   = 0;
  int            cur_word;
  logic          target;
  logic          prev_req  = 1'b0;
  logic          prev_done = 1'b0;
  logic [DW-1:0] held      = '0;
  int            exp_count = 0;
  int            exp_rises = 0;
  logic          exp_err   = 1'b0;

  // Drive source/slave on the falling edge, then observe 1 ns later.
  always begin
    @(negedge clk);
    src_phase++;
    if (src_q.size() > 0 &&
        (src_mode == 0 ||
         (src_mode == 1 && (src_phase % 3) == 0) ||
         (src_mode == 2 && $urandom_range(1) == 1))) begin
      src_valid = 1'b1;
      src_data  = src_q[0];
    end else begin
      src_valid = 1'b0;
      src_data  = DW'($urandom);
    end

    cur_word = rises + ((req && !prev_req) ? 1 : 0);
    target   = req && !(stuck_word != 0 && cur_word == stuck_word);
    if (rst) begin
      ack     = 1'b0;
      dly_cnt = 0;
    end else if (ack != target) begin
      if (dly_cnt == 0) begin
        ack     = target;
        dly_cnt = $urandom_range(max_dly);
      end else begin
        dly_cnt--;
      end
    end

    #1;
    if (rst) begin
      acc_q.delete();
      prev_req  = 1'b0;
      prev_done = 1'b0;
      req_hi    = 0;
    end else begin
      if (src_valid && src_ready) begin
        check_eq("ready_ctx", 32'({busy, req}), 32'h2);
        acc_q.push_back(src_q.pop_front());
      end
      if (req) begin
        if (!prev_req) begin
          rises++;
          req_hi = 0;
          check_eq("req_has_word", 32'(acc_q.size() > 0), 1);
          if (acc_q.size() > 0) check_eq("req_word", 32'(data), 32'(acc_q.pop_front()));
          held = data;
        end else begin
          check_eq("data_hold", 32'(data), 32'(held));
        end
        req_hi++;
      end else if (prev_req && stuck_word != 0 && rises == stuck_word) begin
        check_eq("tmo_req_cycles", req_hi, TMO);
      end
      if (done) begin
        check_eq("done_pulse", 32'(prev_done), 0);
        check_eq("done_count", 32'(count), exp_count);
        check_eq("done_err", 32'(err), 32'(exp_err));
        check_eq("done_rises", rises, exp_rises);
        check_eq("done_acc_empty", acc_q.size(), 0);
        done_cnt++;
      end
      prev_req  = req;
      prev_done = done;
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic check_reset_vals();
    check_eq("rst_req", 32'(req), 0);
    check_eq("rst_data", 32'(data), 0);
    check_eq("rst_src_ready", 32'(src_ready), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_count", 32'(count), 0);
  endtask

  // word_kind: 0 random, 1 0x11,0x22,..., 2 0xA0,0xA1,...
  task automatic run_burst(input int len, input int mode, input int dly,
                           input int stuck, input int word_kind, input bit chk_lat);
    int exp_len;
    int nfill;
    int pulled;
    int d0;
    exp_len = (len > MB) ? MB : len;
    nfill   = exp_len + 2;
    src_q.delete();
    for (int i = 0; i < nfill; i++) begin
      if (word_kind == 1)      src_q.push_back(DW'(8'h11 * (i + 1)));
      else if (word_kind == 2) src_q.push_back(DW'(8'hA0 + i));
      else                     src_q.push_back(DW'($urandom));
    end
    src_mode   = mode;
    max_dly    = dly;
    stuck_word = stuck;
    exp_count  = (stuck != 0) ? stuck - 1 : exp_len;
    exp_rises  = (stuck != 0) ? stuck : exp_len;
    exp_err    = (stuck != 0);
    pulled     = (stuck != 0) ? stuck : exp_len;
    rises      = 0;
    d0         = done_cnt;

    burst_len = LW'(len);
    start     = 1'b1;
    step();
    start     = 1'b0;
    burst_len = LW'($urandom);
    check_eq("start_busy", 32'(busy), 1);
    check_eq("start_err_clr", 32'(err), 0);
    check_eq("start_count", 32'(count), 0);
    if (len == 0) check_eq("len0_done_at_1", 32'(done), 1);
    if (chk_lat) begin
      check_eq("lat_req_at_1", 32'(req), 0);
      step();
      check_eq("lat_req_at_2", 32'(req), 1);
    end
    for (int c = 0; c < 3000 && done_cnt == d0; c++) step();
    for (int c = 0; c < 3; c++) step();
    check_eq("done_once", done_cnt - d0, 1);
    check_eq("busy_after", 32'(busy), 0);
    check_eq("src_pulled", nfill - src_q.size(), pulled);
    src_q.delete();
    stuck_word = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  found;
    logic pr;

    rst = 1'b1;
    step();
    step();
    check_reset_vals();
    rst = 1'b0;
    step();
    check_eq("idle_busy", 32'(busy), 0);

    run_burst(4, 0, 0, 0, 2, 1'b1);
    run_burst(0, 0, 0, 0, 0, 1'b0);
    run_burst(20, 0, 1, 0, 0, 1'b0);
    run_burst(3, 1, 0, 0, 1, 1'b0);
    run_burst(4, 0, 0, 2, 0, 1'b0);
    run_burst(1, 0, 0, 0, 0, 1'b0);

    // Reset in the middle of word 2's release phase.
    src_q.delete();
    for (int i = 0; i < 4; i++) src_q.push_back(DW'($urandom));
    src_mode   = 0;
    max_dly    = 0;
    stuck_word = 0;
    rises      = 0;
    burst_len  = LW'(4);
    start      = 1'b1;
    step();
    start = 1'b0;
    found = 0;
    pr    = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (!req && pr && count == LW'(1)) begin
        found = 1;
        break;
      end
      pr = req;
    end
    check_eq("rst_point_found", found, 1);
    rst = 1'b1;
    step();
    check_reset_vals();
    rst = 1'b0;
    step();
    run_burst(2, 0, 0, 0, 0, 1'b0);

    for (int b = 0; b < 12; b++) begin
      run_burst($urandom_range(20), 2, $urandom_range(3), 0, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
